// File: rtl/clock_div_pkg.sv
// Shared constants for the runtime-selectable clock divider: half-period table,
// controller state encoding and default selection widths.
package clock_div_pkg;

    localparam int DEF_SEL_W = 2;
    localparam int DEF_N_SEL = 4;

    // Half-period of clk_out in clk_in cycles, indexed by selection code.
    localparam int unsigned HALF_TABLE [4] = '{32'd1, 32'd2, 32'd5, 32'd50};

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } ctrl_state_e;

    function automatic int unsigned half_of(input int unsigned sel);
        return (sel < 32'd4) ? HALF_TABLE[sel[1:0]] : HALF_TABLE[0];
    endfunction

endpackage

// File: rtl/clock_div_core.sv
// Toggle counter producing a 50 % duty clk_out from a loadable half-period.
// Optional tick output is compiled in with CLKDIV_CTRL_TICK_EN.
module clock_div_core #(
    parameter int CNT_W = 32
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [CNT_W-1:0] half,
    output logic             clk_out,
    output logic             boundary
`ifdef CLKDIV_CTRL_TICK_EN
    ,
    output logic             tick
`endif
);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap     = (cnt == half - CNT_W'(1));
    // The falling-edge wrap is the only point where a new half-period may take over.
    assign boundary = wrap && clk_out;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (wrap) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
        end else begin
            cnt     <= cnt + CNT_W'(1);
        end
    end

`ifdef CLKDIV_CTRL_TICK_EN
    always_ff @(posedge clk_in) begin
        if (reset) begin
            tick <= 1'b0;
        end else begin
            tick <= wrap && !clk_out;
        end
    end
`endif

endmodule

// File: rtl/clock_div_controller.sv
// Glitch-free clock divider controller: accepts divide-ratio changes and applies
// them on a clk_out falling edge. Define CLKDIV_CTRL_TICK_EN to add the tick output.
module clock_div_controller
    import clock_div_pkg::*;
#(
    parameter int SEL_W     = DEF_SEL_W,
    parameter int N_SEL     = DEF_N_SEL,
    parameter int RESET_SEL = 0,
    parameter int CNT_W     = 32
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [SEL_W-1:0] sel_req,
    input  logic             sel_valid,
    output logic             sel_ready,
    output logic             clk_out,
    output logic [SEL_W-1:0] sel_cur,
    output logic             busy
`ifdef CLKDIV_CTRL_TICK_EN
    ,
    output logic             tick
`endif
);

    localparam logic [31:0] N_SEL_U = 32'(N_SEL);

    ctrl_state_e      state;
    logic [SEL_W-1:0] sel_next;
    logic [CNT_W-1:0] half_cur;
    logic             boundary;
    logic             req_useful;

    // Handshake: a request transfers on any clk_in edge where sel_valid and
    // sel_ready are both high; the requester holds sel_req/sel_valid until then.
    assign sel_ready  = (state == RUN) && !reset;
    assign busy       = (state == PEND);
    assign half_cur   = CNT_W'(half_of(32'(sel_cur)));
    assign req_useful = (sel_req != sel_cur) && (32'(sel_req) < N_SEL_U);

    clock_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk_in   (clk_in),
        .reset    (reset),
        .half     (half_cur),
        .clk_out  (clk_out),
        .boundary (boundary)
`ifdef CLKDIV_CTRL_TICK_EN
        ,
        .tick     (tick)
`endif
    );

    // A request accepted on the boundary edge itself only becomes PEND after
    // that edge, so it waits for the following falling edge.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state    <= RUN;
            sel_cur  <= SEL_W'(RESET_SEL);
            sel_next <= SEL_W'(RESET_SEL);
        end else begin
            case (state)
                RUN: begin
                    if (sel_valid && req_useful) begin
                        sel_next <= sel_req;
                        state    <= PEND;
                    end
                end
                PEND: begin
                    if (boundary) begin
                        sel_cur <= sel_next;
                        state   <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_div_controller.sv
// Directed plus randomized bench for clock_div_controller with a cycle-level
// reference model based on elapsed cycles within the current rate segment.
module tb_clock_div_controller;

    localparam int SEL_W     = 2;
    localparam int N_SEL     = 4;
    localparam int RESET_SEL = 0;
    localparam int CNT_W     = 32;

    logic             clk_in    = 1'b0;
    logic             reset     = 1'b1;
    logic [SEL_W-1:0] sel_req   = '0;
    logic             sel_valid = 1'b0;
    logic             sel_ready;
    logic             clk_out;
    logic [SEL_W-1:0] sel_cur;
    logic             busy;
`ifdef CLKDIV_CTRL_TICK_EN
    logic             tick;
`endif

    int tests = 0;
    int fails = 0;

    // clock/reset block
    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    clock_div_controller #(
        .SEL_W     (SEL_W),
        .N_SEL     (N_SEL),
        .RESET_SEL (RESET_SEL),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .sel_req   (sel_req),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .clk_out   (clk_out),
        .sel_cur   (sel_cur),
        .busy      (busy)
`ifdef CLKDIV_CTRL_TICK_EN
        ,
        .tick      (tick)
`endif
    );

    // reference model: m_k = clk_in edges since the current rate segment began
    int unsigned half_tbl [4] = '{1, 2, 5, 50};
    int m_k    = 0;
    int m_half = 1;
    int m_cur  = RESET_SEL;
    int m_next = 0;
    bit m_pend = 1'b0;

    // scoreboard entry: {clk_out, tick, busy, sel_cur[1:0]}
    logic [4:0] exp_q [$];

    function automatic bit exp_clk();
        return ((m_k / m_half) % 2) == 1;
    endfunction

    function automatic bit exp_tick();
        return (m_k > 0) && ((m_k % m_half) == 0) && (((m_k / m_half) % 2) == 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [SEL_W-1:0] r, input logic rst, input bit acc);
        if (rst) begin
            m_k    = 0;
            m_cur  = RESET_SEL;
            m_half = int'(half_tbl[RESET_SEL]);
            m_pend = 1'b0;
        end else begin
            m_k++;
            if (m_pend && (m_k % (2 * m_half)) == 0) begin
                m_cur  = m_next;
                m_half = int'(half_tbl[m_cur]);
                m_k    = 0;
                m_pend = 1'b0;
            end else if (acc && int'(r) != m_cur && int'(r) < N_SEL) begin
                m_pend = 1'b1;
                m_next = int'(r);
            end
        end
        exp_q.push_back({exp_clk(), exp_tick(), m_pend, 2'(m_cur)});
    endtask

    // driver: one clk_in cycle, inputs applied and outputs checked at negedge
    task automatic step(input logic v, input logic [SEL_W-1:0] r, input logic rst, output bit acc);
        bit         m_ready;
        logic [4:0] e;
        sel_valid = v;
        sel_req   = r;
        reset     = rst;
        #1;
        m_ready = !m_pend && !rst;
        check("sel_ready", 32'(sel_ready), 32'(m_ready));
        acc = v && m_ready;
        @(posedge clk_in);
        model_edge(r, rst, acc);
        @(negedge clk_in);
        e = exp_q.pop_front();
        check("clk_out", 32'(clk_out), 32'(e[4]));
        check("busy", 32'(busy), 32'(e[2]));
        check("sel_cur", 32'(sel_cur), 32'(e[1:0]));
`ifdef CLKDIV_CTRL_TICK_EN
        check("tick", 32'(tick), 32'(e[3]));
`endif
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, acc);
    endtask

    task automatic request(input logic [SEL_W-1:0] s);
        bit acc = 1'b0;
        int n   = 0;
        while (!acc && n < 200) begin
            step(1'b1, s, 1'b0, acc);
            n++;
        end
        check("req_accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            idle(1);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        bit               acc;
        bit               holding;
        logic [SEL_W-1:0] hreq;
        int               n;
        int               nticks;

        @(negedge clk_in);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, acc);
        check("reset_clk_out", 32'(clk_out), 32'd0);
        check("reset_sel_cur", 32'(sel_cur), 32'(RESET_SEL));
        idle(10);

        // sel0 -> sel2
        request(2'd2);
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_idle();
        idle(25);
        check("sel_cur_sel2", 32'(sel_cur), 32'd2);

        // same selection is discarded
        request(2'd2);
        check("same_sel_no_busy", 32'(busy), 32'd0);
        idle(20);

        // reset while a change is pending
        request(2'd3);
        wait_idle();
        request(2'd1);
        idle(3);
        check("pending_busy", 32'(busy), 32'd1);
        step(1'b0, '0, 1'b1, acc);
        check("rst_pend_busy", 32'(busy), 32'd0);
        check("rst_pend_sel", 32'(sel_cur), 32'(RESET_SEL));
        check("rst_pend_clk", 32'(clk_out), 32'd0);
        idle(150);
        check("pending_dropped", 32'(sel_cur), 32'(RESET_SEL));

        // at sel3, request sel0 exactly in the boundary cycle
        request(2'd3);
        wait_idle();
        n = 0;
        while (((m_k + 1) % (2 * m_half)) != 0 && n < 200) begin
            idle(1);
            n++;
        end
        step(1'b1, 2'd0, 1'b0, acc);
        check("boundary_accept", 32'(acc), 32'd1);
        n = 0;
        while (sel_cur != 2'd0 && n < 300) begin
            idle(1);
            n++;
        end
        check("boundary_latency", 32'(n), 32'd100);
        idle(10);

`ifdef CLKDIV_CTRL_TICK_EN
        request(2'd1);
        wait_idle();
        idle(8);
        nticks = 0;
        for (int i = 0; i < 16; i++) begin
            idle(1);
            if (tick) nticks++;
        end
        check("tick_count_sel1", 32'(nticks), 32'd4);
`else
        nticks = 0;
`endif

        // randomized requests with occasional resets
        holding = 1'b0;
        hreq    = '0;
        for (int i = 0; i < 900; i++) begin
            if (!holding && $urandom_range(0, 5) == 0) begin
                holding = 1'b1;
                hreq    = SEL_W'($urandom_range(0, 3));
            end
            step(holding, hreq, ($urandom_range(0, 149) == 0), acc);
            if (acc) holding = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
